// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_transmitter among NUM_REQ byte producers.
// Latches the winner's byte plus its 9th bit, tracks busy through one frame, then acks or errs.

module uart_tx_arb_frame #(
    parameter int PARITY_MODE = 0
) (
    input  logic [7:0] data_in,
    output logic [8:0] frame
);
    logic bit8;

    always_comb begin
        case (PARITY_MODE)
            0:       bit8 = ^data_in;
            1:       bit8 = ~^data_in;
            default: bit8 = 1'b1;
        endcase
        frame = {bit8, data_in};
    end
endmodule

module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int PARITY_MODE  = 0,
    parameter int BUSY_TIMEOUT = 1023
) (
    input  logic                       clk,
    input  logic                       l_ready_reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [8*NUM_REQ-1:0]       req_data,
    output logic [NUM_REQ-1:0]         ack,
    output logic [NUM_REQ-1:0]         err,
    output logic [8:0]                 tx_data,
    output logic                       tx_send,
    input  logic                       tx_busy,
    output logic [$clog2(NUM_REQ)-1:0] owner,
    output logic                       active
);
    localparam int OW = $clog2(NUM_REQ);
    localparam int CW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;

    state_t                      state, state_nxt;
    logic [CW-1:0]               cnt;
    logic [NUM_REQ-1:0][8:0]     frame;
    logic [OW-1:0]               winner;
    logic [OW-1:0]               cand;
    logic                        found;
    logic                        timeout;

    // Each requester's framed word is ready before arbitration, so the grant edge just muxes.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_frame
        uart_tx_arb_frame #(.PARITY_MODE(PARITY_MODE)) u_frame (
            .data_in (req_data[8*i +: 8]),
            .frame   (frame[i])
        );
    end

    // Rotating search from owner+1 so the last-served requester ends up lowest priority.
    always_comb begin
        winner = owner;
        cand   = owner;
        found  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (cand == OW'(NUM_REQ - 1)) ? '0 : cand + OW'(1);
            if (!found && req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    assign timeout = (state == SEND) && !tx_busy && (cnt == CW'(BUSY_TIMEOUT - 1));

    always_ff @(posedge clk or posedge l_ready_reset) begin
        if (l_ready_reset) state <= IDLE;
        else               state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (found) state_nxt = SEND;
            SEND: begin
                if (tx_busy)      state_nxt = WAIT;
                else if (timeout) state_nxt = IDLE;
            end
            WAIT: if (!tx_busy) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge l_ready_reset) begin
        if (l_ready_reset) begin
            owner   <= OW'(NUM_REQ - 1);
            tx_data <= '0;
            cnt     <= '0;
            err     <= '0;
        end else begin
            err <= '0;
            if (timeout) err[owner] <= 1'b1;
            if (state == IDLE && found) begin
                owner   <= winner;
                tx_data <= frame[winner];
                cnt     <= '0;
            end else if (state == SEND && !tx_busy && !timeout) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    always_comb begin
        ack = '0;
        if (state == DONE) ack[owner] = 1'b1;
    end

    assign tx_send = (state == SEND);
    assign active  = (state != IDLE);
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: three DUTs (one per parity mode) share stimulus,
// a transmitter model drives busy, and a monitor pops expected grants and ack/err pulses.

module tb_uart_tx_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic        tx_busy;
    logic        model_en;

    logic [3:0] ack0, err0, ack1, err1, ack2, err2;
    logic [8:0] tx_data0, tx_data1, tx_data2;
    logic       tx_send0, tx_send1, tx_send2;
    logic [1:0] owner0, owner1, owner2;
    logic       active0, active1, active2;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [1:0] own;
        logic [8:0] d0;
        logic [8:0] d1;
        logic [8:0] d2;
    } grant_t;
    typedef struct packed {
        logic [3:0] a;
        logic [3:0] e;
    } resp_t;

    grant_t gq[$];
    resp_t  rq[$];
    grant_t g;
    resp_t  r;
    logic   prev_send;
    int     bcnt;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(4), .PARITY_MODE(0), .BUSY_TIMEOUT(8)) dut0 (
        .clk(clk), .l_ready_reset(rst), .req(req), .req_data(req_data),
        .ack(ack0), .err(err0), .tx_data(tx_data0), .tx_send(tx_send0),
        .tx_busy(tx_busy), .owner(owner0), .active(active0));
    uart_tx_arbiter #(.NUM_REQ(4), .PARITY_MODE(1), .BUSY_TIMEOUT(8)) dut1 (
        .clk(clk), .l_ready_reset(rst), .req(req), .req_data(req_data),
        .ack(ack1), .err(err1), .tx_data(tx_data1), .tx_send(tx_send1),
        .tx_busy(tx_busy), .owner(owner1), .active(active1));
    uart_tx_arbiter #(.NUM_REQ(4), .PARITY_MODE(2), .BUSY_TIMEOUT(8)) dut2 (
        .clk(clk), .l_ready_reset(rst), .req(req), .req_data(req_data),
        .ack(ack2), .err(err2), .tx_data(tx_data2), .tx_send(tx_send2),
        .tx_busy(tx_busy), .owner(owner2), .active(active2));

    // Transmitter model: busy rises a couple of cycles after send, stays high 10 cycles.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_busy <= 1'b0;
            bcnt    <= 0;
        end else if (bcnt != 0) begin
            bcnt <= bcnt + 1;
            if (bcnt == 2) tx_busy <= 1'b1;
            if (bcnt == 12) begin
                tx_busy <= 1'b0;
                bcnt    <= 0;
            end
        end else if (tx_send0 && model_en) begin
            bcnt <= 1;
        end
    end

    // Monitor: compare every grant (tx_send rise) and every ack/err pulse with the queues.
    always @(negedge clk) begin
        if (rst) begin
            prev_send <= 1'b0;
        end else begin
            if (tx_send0 && !prev_send) begin
                tests++;
                if (gq.size() == 0) begin
                    fails++;
                    $display("FAIL grant: unexpected grant owner=%0d data=%h", owner0, tx_data0);
                end else begin
                    g = gq.pop_front();
                    if (owner0 !== g.own || tx_data0 !== g.d0 || tx_data1 !== g.d1 || tx_data2 !== g.d2) begin
                        fails++;
                        $display("FAIL grant: got owner=%0d data=%h/%h/%h, expected owner=%0d data=%h/%h/%h",
                                 owner0, tx_data0, tx_data1, tx_data2, g.own, g.d0, g.d1, g.d2);
                    end
                end
            end
            if ((ack0 | err0) != 4'b0) begin
                tests++;
                if (rq.size() == 0) begin
                    fails++;
                    $display("FAIL resp: unexpected ack=%b err=%b", ack0, err0);
                end else begin
                    r = rq.pop_front();
                    if (ack0 !== r.a || err0 !== r.e || ack1 !== r.a || err2 !== r.e) begin
                        fails++;
                        $display("FAIL resp: got ack=%b err=%b, expected ack=%b err=%b", ack0, err0, r.a, r.e);
                    end
                end
            end
            prev_send <= tx_send0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_g(input logic [1:0] own, input logic [8:0] d0, input logic [8:0] d1, input logic [8:0] d2);
        gq.push_back('{own: own, d0: d0, d1: d1, d2: d2});
    endtask

    task automatic push_r(input logic [3:0] a, input logic [3:0] e);
        rq.push_back('{a: a, e: e});
    endtask

    task automatic wait_resp(input string name);
        int k;
        k = 0;
        @(negedge clk);
        while ((ack0 | err0) == 4'b0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k >= 100) begin
            tests++;
            fails++;
            $display("FAIL %s: no ack/err within 100 cycles", name);
        end
    endtask

    task automatic wait_busy(input string name);
        int k;
        k = 0;
        @(negedge clk);
        while (!tx_busy && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k >= 100) begin
            tests++;
            fails++;
            $display("FAIL %s: busy never rose", name);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, k;
        rst = 1'b1; req = '0; req_data = '0; model_en = 1'b1;
        @(negedge clk);
        chk("reset_owner", 32'(owner0), 32'd3);
        chk("reset_active", 32'(active0), 32'd0);
        chk("reset_send", 32'(tx_send0), 32'd0);
        chk("reset_txdata", 32'(tx_data0), 32'd0);
        chk("reset_ackerr", 32'({ack0, err0}), 32'd0);
        @(negedge clk) rst = 1'b0;

        // single request
        next_cycle();
        req_data[7:0] = 8'hA5; req = 4'b0001;
        push_g(2'd0, 9'h0A5, 9'h1A5, 9'h1A5); push_r(4'b0001, 4'b0000);
        next_cycle();
        chk("send_latency", 32'(tx_send0), 32'd1);
        wait_resp("single");
        req = '0;
        chk("single_owner", 32'(owner0), 32'd0);

        // round robin from a fresh pointer
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        req_data = {8'h43, 8'h32, 8'h21, 8'h10};
        req = 4'b1111;
        push_g(2'd0, 9'h110, 9'h010, 9'h110); push_r(4'b0001, 4'b0000);
        push_g(2'd1, 9'h021, 9'h121, 9'h121); push_r(4'b0010, 4'b0000);
        push_g(2'd2, 9'h132, 9'h032, 9'h132); push_r(4'b0100, 4'b0000);
        push_g(2'd3, 9'h143, 9'h043, 9'h143); push_r(4'b1000, 4'b0000);
        push_g(2'd0, 9'h110, 9'h010, 9'h110); push_r(4'b0001, 4'b0000);
        for (int i = 0; i < 5; i++) wait_resp("rr");
        req = '0;

        // all-ones byte across parity modes
        next_cycle();
        req_data[7:0] = 8'hFF; req = 4'b0001;
        push_g(2'd0, 9'h0FF, 9'h1FF, 9'h1FF); push_r(4'b0001, 4'b0000);
        wait_resp("parity_ff");
        req = '0;

        // busy timeout
        next_cycle();
        model_en = 1'b0; req_data[23:16] = 8'h5A; req = 4'b0100;
        push_g(2'd2, 9'h05A, 9'h15A, 9'h15A); push_r(4'b0000, 4'b0100);
        n = 0; k = 0;
        @(negedge clk);
        while (err0 == 4'b0 && k < 100) begin
            if (tx_send0) n++;
            @(negedge clk);
            k++;
        end
        req = '0;
        chk("timeout_send_cycles", 32'(n), 32'd8);
        chk("timeout_active", 32'(active0), 32'd0);
        chk("timeout_no_ack", 32'(ack0), 32'd0);
        next_cycle();
        model_en = 1'b1; req = 4'b1001;
        push_g(2'd3, 9'h143, 9'h043, 9'h143); push_r(4'b1000, 4'b0000);
        wait_resp("after_timeout");
        req = '0;

        // reset during WAIT
        next_cycle();
        req = 4'b0010;
        push_g(2'd1, 9'h021, 9'h121, 9'h121);
        wait_busy("reset_mid");
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_mid_send", 32'(tx_send0), 32'd0);
        chk("rst_mid_ack", 32'(ack0), 32'd0);
        chk("rst_mid_active", 32'(active0), 32'd0);
        chk("rst_mid_owner", 32'(owner0), 32'd3);
        req = '0;
        @(negedge clk) rst = 1'b0;
        next_cycle();
        req = 4'b1000;
        push_g(2'd3, 9'h143, 9'h043, 9'h143); push_r(4'b1000, 4'b0000);
        wait_resp("after_reset");
        req = '0;

        // request dropped mid-frame
        next_cycle();
        req = 4'b0010;
        push_g(2'd1, 9'h021, 9'h121, 9'h121); push_r(4'b0010, 4'b0000);
        wait_busy("drop");
        req = '0;
        wait_resp("drop");
        repeat (5) next_cycle();
        chk("drop_no_regrant", 32'(active0), 32'd0);

        repeat (2) next_cycle();
        chk("grant_q_empty", 32'(gq.size()), 32'd0);
        chk("resp_q_empty", 32'(rq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
